// File: rtl/vga_pat_pkg.sv
// Shared definitions for the VGA test-pattern path.
//   - RGB565 colour constants used by the pattern generator
//   - pattern index encoding carried on pat_sel
//   - change-request FSM state encoding
package vga_pat_pkg;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

    localparam logic [1:0] PAT_BAR  = 2'd0;
    localparam logic [1:0] PAT_GRID = 2'd1;
    localparam logic [1:0] PAT_GRAD = 2'd2;
    localparam logic [1:0] PAT_CHK  = 2'd3;

    typedef enum logic {
        ST_SHOW = 1'b0,   // no change pending
        ST_PEND = 1'b1    // change waits for the next frame boundary
    } state_t;

    // 128-pixel-wide colour bars selected by column bits [9:7]
    function automatic logic [15:0] bar_colour(input logic [2:0] bar);
        case (bar)
            3'd0:    bar_colour = WHITE;
            3'd1:    bar_colour = BLACK;
            3'd2:    bar_colour = RED;
            3'd3:    bar_colour = GREEN;
            3'd4:    bar_colour = BLUE;
            default: bar_colour = BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pat_gen.sv
// Pattern decode and range blanking for one pixel per clock.
// Ports:
//   i_clk      pixel clock
//   i_rst      synchronous active-high reset
//   i_xpos     active column (0-based)
//   i_ypos     active row (0-based)
//   i_pat_sel  pattern to render for this coordinate
//   o_pixel    registered RGB565 pixel, one clock after the coordinate
module vga_pat_gen
    import vga_pat_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [9:0]  i_xpos,
    input  logic [9:0]  i_ypos,
    input  logic [1:0]  i_pat_sel,
    output logic [15:0] o_pixel
);

    // Limits widened by one bit so a 1024 limit still compares correctly
    localparam logic [10:0] H_LIM = 11'(H_DISP);
    localparam logic [10:0] V_LIM = 11'(V_DISP);

    logic        w_blank;
    logic [15:0] w_pix;
    logic [15:0] r_pixel;

    assign w_blank = ({1'b0, i_xpos} >= H_LIM) || ({1'b0, i_ypos} >= V_LIM);

    always_comb begin
        w_pix = BLACK;
        case (i_pat_sel)
            PAT_BAR:  w_pix = bar_colour(i_xpos[9:7]);
            PAT_GRID: w_pix = ((i_xpos[4:0] == 5'd0) || (i_ypos[4:0] == 5'd0)) ? WHITE : BLACK;
            PAT_GRAD: w_pix = {i_xpos[9:5], 6'd0, i_ypos[8:4]};
            PAT_CHK:  w_pix = (i_xpos[6] ^ i_ypos[6]) ? WHITE : BLACK;
            default:  w_pix = BLACK;
        endcase
        if (w_blank) begin
            w_pix = BLACK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pixel <= BLACK;
        end else begin
            r_pixel <= w_pix;
        end
    end

    assign o_pixel = r_pixel;

endmodule

// File: rtl/vga_pattern_ctrl.sv
// Frame-synchronous test-pattern controller. Pattern change requests
// (debounced key or auto-advance frame counter) are held pending and only
// committed on a vga_vs falling edge, so a frame never tears.
// Ports:
//   vga_clk      pixel clock, only clock
//   sys_rst      synchronous active-high reset
//   vga_vs       vertical sync, active-low; falling edge = frame boundary
//   pixel_xpos   active column from vga_driver
//   pixel_ypos   active row from vga_driver
//   key_next     single-cycle advance request
//   auto_en      level, enables auto-advance every AUTO_FRAMES frames
//   pixel_data   registered RGB565 pixel
//   pat_sel      currently displayed pattern
//   frame_start  registered one-cycle pulse per frame boundary
module vga_pattern_ctrl
    import vga_pat_pkg::*;
#(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int AUTO_FRAMES = 120
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        vga_vs,
    input  logic [9:0]  pixel_xpos,
    input  logic [9:0]  pixel_ypos,
    input  logic        key_next,
    input  logic        auto_en,
    output logic [15:0] pixel_data,
    output logic [1:0]  pat_sel,
    output logic        frame_start
);

    localparam int              CNT_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);

    state_t           r_state, w_state_nxt;
    logic             r_vs_d;
    logic             r_frame_start;
    logic [1:0]       r_pat_sel;
    logic [1:0]       w_pat_nxt;
    logic [CNT_W-1:0] r_frame_cnt, w_cnt_nxt;
    logic             w_boundary;
    logic             w_auto_req;
    logic             w_commit;

    assign w_boundary = r_vs_d & ~vga_vs;

    // Counter only runs in SHOW, so a terminal count is only seen there
    assign w_auto_req = auto_en && (r_state == ST_SHOW) && w_boundary
                        && (r_frame_cnt == CNT_LAST);

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_state <= ST_SHOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request seen in SHOW (even on a boundary cycle) only arms PEND;
    // the commit always waits for a later boundary. Requests in PEND drop.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_SHOW: begin
                if (key_next || w_auto_req) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_boundary) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_SHOW;
                end
            end
            default: w_state_nxt = ST_SHOW;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_frame_cnt;
        if (!auto_en || w_commit) begin
            w_cnt_nxt = '0;
        end else if ((r_state == ST_SHOW) && w_boundary) begin
            w_cnt_nxt = (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
    end

    assign w_pat_nxt = w_commit ? r_pat_sel + 2'd1 : r_pat_sel;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_vs_d        <= 1'b1;
            r_frame_start <= 1'b0;
            r_pat_sel     <= PAT_BAR;
            r_frame_cnt   <= '0;
        end else begin
            r_vs_d        <= vga_vs;
            r_frame_start <= w_boundary;
            r_pat_sel     <= w_pat_nxt;
            r_frame_cnt   <= w_cnt_nxt;
        end
    end

    // Generator sees the next pattern so the pixel registered on a commit
    // edge already uses the new selection.
    vga_pat_gen #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_gen (
        .i_clk     (vga_clk),
        .i_rst     (sys_rst),
        .i_xpos    (pixel_xpos),
        .i_ypos    (pixel_ypos),
        .i_pat_sel (w_pat_nxt),
        .o_pixel   (pixel_data)
    );

    assign pat_sel     = r_pat_sel;
    assign frame_start = r_frame_start;

endmodule
